// File: rtl/key_event_encoder.sv
// Key event encoder: scans debounced key levels round-robin against the
// last reported level and queues one {key, press} event per detected change
// in a small first-word-fall-through FIFO drained by a valid/ready consumer.
module key_event_encoder #(
    parameter int NUM_KEYS = 8,
    parameter int KEY_W    = 3,
    parameter int FIFO_AW  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                enable,
    input  logic                event_ready,
    output logic                event_valid,
    output logic [KEY_W-1:0]    event_key,
    output logic                event_press,
    output logic [FIFO_AW:0]    fifo_count,
    output logic [NUM_KEYS-1:0] key_state
);

    localparam int               DEPTH    = 2**FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW+1)'(DEPTH);
    localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(NUM_KEYS-1);

    typedef enum logic {PRIME, RUN} state_t;

    state_t              state;
    logic [NUM_KEYS-1:0] key_q;
    logic [NUM_KEYS-1:0] reported;
    logic [KEY_W-1:0]    ptr;

    // Each entry is {key index, press flag}
    logic [KEY_W:0]      mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [FIFO_AW:0]    count;

    logic                scan;
    logic                mismatch;
    logic                full;
    logic                push;
    logic                pop;
    logic                advance;
    logic [KEY_W-1:0]    ptr_next;

    // Scan decision for the key under the pointer; full uses the registered
    // count so a same-cycle pop never opens a slot for a push.
    always_comb begin
        scan     = (state == RUN) && enable;
        mismatch = key_q[ptr] != reported[ptr];
        full     = count == DEPTH_C;
        push     = scan && mismatch && !full;
        advance  = scan && !(mismatch && full);
        ptr_next = (ptr == LAST_KEY) ? '0 : ptr + KEY_W'(1);
        pop      = (count != '0) && event_ready;
    end

    // Scanner FSM: PRIME adopts the current levels silently, RUN reports changes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= PRIME;
            key_q    <= '0;
            reported <= '0;
            ptr      <= '0;
        end else begin
            key_q <= keys;
            case (state)
                PRIME: begin
                    reported <= keys;
                    state    <= RUN;
                end
                RUN: begin
                    if (push) begin
                        reported[ptr] <= key_q[ptr];
                    end
                    if (advance) begin
                        ptr <= ptr_next;
                    end
                end
                default: state <= PRIME;
            endcase
        end
    end

    // Event FIFO: write on push, retire head on pop, count tracks occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {ptr, key_q[ptr]};
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign event_valid              = count != '0;
    assign {event_key, event_press} = mem[rd_ptr];
    assign fifo_count               = count;
    assign key_state                = reported;

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_key_event_encoder;

    localparam int NK    = 8;
    localparam int DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] keys = 8'h00;
    logic       enable = 1'b0;
    logic       event_ready = 1'b0;
    logic       event_valid;
    logic [2:0] event_key;
    logic       event_press;
    logic [3:0] fifo_count;
    logic [7:0] key_state;

    key_event_encoder #(.NUM_KEYS(8), .KEY_W(3), .FIFO_AW(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .keys        (keys),
        .enable      (enable),
        .event_ready (event_ready),
        .event_valid (event_valid),
        .event_key   (event_key),
        .event_press (event_press),
        .fifo_count  (fifo_count),
        .key_state   (key_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int k;
        bit p;
        int c;
    } ev_t;

    int   nvec = 0;
    int   nerr = 0;
    bit   chk_en = 1'b0;
    int   cyc_n = 0;
    ev_t  mq[$];
    ev_t  log_q[$];
    bit [7:0] m_keyq = 8'h00;
    bit [7:0] m_rep = 8'h00;
    int   m_ptr = 0;
    bit   m_prime = 1'b1;
    int   m_cnt;
    bit   m_pop;
    ev_t  m_e;
    ev_t  l_e;

    task automatic check(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    function automatic int count_key(int k);
        int n = 0;
        foreach (log_q[i]) if (log_q[i].k == k) n++;
        return n;
    endfunction

    // Reference model: snapshot levels, a last-reported vector, a scan index
    // and a plain queue of pending events.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_keyq  = 8'h00;
            m_rep   = 8'h00;
            m_ptr   = 0;
            m_prime = 1'b1;
        end else begin
            m_cnt = mq.size();
            m_pop = (m_cnt != 0) && event_ready;
            if (m_pop) mq.delete(0);
            if (m_prime) begin
                m_keyq  = keys;
                m_rep   = keys;
                m_prime = 1'b0;
            end else begin
                if (enable) begin
                    if (m_keyq[m_ptr] != m_rep[m_ptr]) begin
                        if (m_cnt < DEPTH) begin
                            m_e.k = m_ptr;
                            m_e.p = m_keyq[m_ptr];
                            m_e.c = 0;
                            mq.push_back(m_e);
                            m_rep[m_ptr] = m_keyq[m_ptr];
                            m_ptr = (m_ptr + 1) % NK;
                        end
                    end else begin
                        m_ptr = (m_ptr + 1) % NK;
                    end
                end
                m_keyq = keys;
            end
        end
    end

    // Record every event the DUT hands over, with the cycle it was taken.
    always @(posedge clock) begin
        cyc_n <= cyc_n + 1;
        if (!reset && event_valid && event_ready) begin
            l_e.k = int'(event_key);
            l_e.p = event_press;
            l_e.c = cyc_n;
            log_q.push_back(l_e);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("valid", int'(event_valid), int'(mq.size() != 0));
            check("fifo_count", int'(fifo_count), mq.size());
            check("key_state", int'(key_state), int'(m_rep));
            if (event_valid && mq.size() != 0) begin
                check("head_key", int'(event_key), mq[0].k);
                check("head_press", int'(event_press), int'(mq[0].p));
            end
        end
    end

    initial begin
        int lat;
        int hk;
        int hp;

        // Keys held through reset produce nothing
        keys        = 8'h05;
        enable      = 1'b1;
        event_ready = 1'b1;
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        cyc(3);
        check("rst_valid", int'(event_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_key", int'(event_key), 0);
        check("rst_press", int'(event_press), 0);
        check("rst_state", int'(key_state), 0);
        reset = 1'b0;
        cyc(20);
        check("held_state", int'(key_state), 8'h05);
        check("held_events", log_q.size(), 0);

        // Single press and release of key 3
        keys = 8'h00;
        cyc(12);
        log_q.delete();
        keys = 8'h08;
        lat = 0;
        hk  = -1;
        hp  = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (event_valid) begin
                lat = i;
                hk  = int'(event_key);
                hp  = int'(event_press);
                break;
            end
        end
        #1;
        check("press_latency_in_2_9", int'(lat >= 2 && lat <= 9), 1);
        check("press_key", hk, 3);
        check("press_type", hp, 1);
        cyc(3);
        check("press_count", log_q.size(), 1);
        keys = 8'h00;
        cyc(12);
        check("release_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("release_key", log_q[1].k, 3);
            check("release_type", int'(log_q[1].p), 0);
        end
        check("release_state", int'(key_state), 0);

        // All keys pressed at once: round-robin, back-to-back, no duplicates
        log_q.delete();
        keys = 8'hFF;
        cyc(20);
        check("all_count", log_q.size(), 8);
        if (log_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("all_order", log_q[i].k, (log_q[0].k + i) % 8);
                check("all_press", int'(log_q[i].p), 1);
                check("all_b2b", log_q[i].c, log_q[0].c + i);
            end
        end
        check("all_state", int'(key_state), 8'hFF);

        // Backpressure, stall on key 0 and coalescing of key 1's pulse
        keys = 8'h00;
        cyc(20);
        log_q.delete();
        event_ready = 1'b0;
        keys = 8'hFF;
        cyc(15);
        check("bp_full", int'(fifo_count), 8);
        keys = 8'hFE;
        cyc(12);
        check("bp_stall_full", int'(fifo_count), 8);
        check("bp_stall_state0", int'(key_state[0]), 1);
        keys = 8'hFC;
        cyc(3);
        keys = 8'hFE;
        cyc(3);
        event_ready = 1'b1;
        cyc(1);
        event_ready = 1'b0;
        check("bp_one_pop", log_q.size(), 1);
        cyc(5);
        check("bp_refill", int'(fifo_count), 8);
        check("bp_state0_cleared", int'(key_state[0]), 0);
        event_ready = 1'b1;
        cyc(15);
        check("bp_total", log_q.size(), 9);
        check("bp_key1_events", count_key(1), 1);
        if (log_q.size() == 9) begin
            check("bp_last_key", log_q[8].k, 0);
            check("bp_last_type", int'(log_q[8].p), 0);
        end
        check("bp_drained", int'(fifo_count), 0);

        // Enable gating
        keys = 8'h00;
        cyc(20);
        log_q.delete();
        enable = 1'b0;
        keys = 8'h81;
        cyc(20);
        check("en_off_events", log_q.size(), 0);
        check("en_off_count", int'(fifo_count), 0);
        check("en_off_state", int'(key_state), 0);
        enable = 1'b1;
        cyc(12);
        check("en_on_events", log_q.size(), 2);
        check("en_on_key0", count_key(0), 1);
        check("en_on_key7", count_key(7), 1);
        check("en_on_state", int'(key_state), 8'h81);

        // Asynchronous reset with five events queued
        event_ready = 1'b0;
        keys = 8'h9E;
        cyc(15);
        check("ar_count5", int'(fifo_count), 5);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid_now", int'(event_valid), 0);
        check("ar_count_now", int'(fifo_count), 0);
        check("ar_state_now", int'(key_state), 0);
        check("ar_key_now", int'(event_key), 0);
        log_q.delete();
        cyc(1);
        reset = 1'b0;
        event_ready = 1'b1;
        cyc(10);
        check("ar_prime_events", log_q.size(), 0);
        check("ar_prime_state", int'(key_state), 8'h9E);
        check("ar_prime_count", int'(fifo_count), 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/key_event_encoder.md
# key_event_encoder

Converts the debounced key-sensor levels of the projected piano into a stream of discrete press/release events, one key per event, buffered in a small FIFO. Sits directly downstream of the per-key debounce stages in the sensor module and feeds the note/sound logic through a valid/ready handshake. Events are derived by comparing current stable levels against the last reported level, so no transition is ever silently lost. Rapid toggles that occur while the FIFO is backed up coalesce into the net change.

## Interface
- NUM_KEYS, 8: number of debounced key inputs; must not exceed 2**KEY_W.
- KEY_W, 3: width of the key index.
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW = 8.

- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- keys  in  NUM_KEYS  debounced steady levels; 1 = pressed.
- enable  in  1  scanner enable; when 0, no events are generated.
- event_ready  in  1  consumer accepts the head event.
- event_valid  out  1  FIFO non-empty; head event is presented.
- event_key  out  KEY_W  key index of the head event.
- event_press  out  1  head event type; 1 = press, 0 = release.
- fifo_count  out  FIFO_AW+1  number of queued events, range 0..2**FIFO_AW.
- key_state  out  NUM_KEYS  last reported level per key (`reported`).

## Operation
- Registers:
  - `key_q`: `keys` sampled every clock.
  - `reported`: NUM_KEYS bits.
  - `ptr`: scan pointer, KEY_W bits.
  - FIFO storage of {key, press}, 2**FIFO_AW entries.
  - `count`.
  - `state` ∈ {PRIME, RUN}.
- Reset (asynchronous, takes effect immediately without a clock edge):
  - `key_q`=0, `reported`=0, `ptr`=0, FIFO cleared, `count`=0, `state`=PRIME.
  - Outputs: event_valid=0, fifo_count=0, key_state=0. event_key and event_press read 0.
- PRIME lasts exactly one clock after reset release:
  - `key_q` <= `keys`, `reported` <= `keys`.
  - No event is generated, then `state` -> RUN.
  - Keys held during reset therefore produce no event.
- RUN, each clock:
  - `key_q` <= `keys`.
  - If enable=1, examine key `ptr`:
    - If `key_q[ptr] != reported[ptr]` and `count < 2**FIFO_AW`: push {ptr, key_q[ptr]} and set `reported[ptr]` <= `key_q[ptr]`.
    - Then `ptr` advances (wrapping at NUM_KEYS-1 -> 0).
    - If a mismatch exists but the FIFO is full: no push, `ptr` holds on that key.
    - If there is no mismatch: `ptr` advances.
  - If enable=0: `ptr` holds and no push occurs; `key_q` keeps sampling.
- Coalescing: a key that toggles and returns to its `reported` level before being scanned generates no event.
- Pop: occurs when event_valid && event_ready. FIFO output is first-word-fall-through.
- Full test uses the registered `count`. A pop in the same cycle does not unblock a push.
- A simultaneous push and pop leaves `count` unchanged.
- event_ready while empty is ignored.
- Pointers wrap modulo depth.

## Timing
- Input change sampled into `key_q` at edge k. The earliest push is at edge k+1, and event_valid is high after edge k+1.
- Minimum latency: 2 clocks (key change to event_valid).
- Maximum latency with FIFO not full and enable=1: NUM_KEYS+1 clocks.
- event_valid, event_key and event_press are stable while event_valid=1 and event_ready=0.
- fifo_count and key_state update on the same edge as push/pop.
- Throughput: at most one push and one pop per clock.

## Test plan
- **No events for keys held through reset:** hold keys=8'h05 through reset, release reset, run 20 clocks with event_ready=1 -> event_valid stays 0 and key_state=8'h05.
- **Single press and release:** keys 0 -> 8'h08 with event_ready=1 -> within 2..9 clocks event {key=3, press=1} is valid for exactly one cycle. Then keys -> 0 -> event {key=3, press=0}, and key_state returns to 0.
- **All keys at once, round-robin order:** keys 0 -> 8'hFF in one cycle, event_ready=1 -> exactly 8 press events, one per key, in round-robin order starting from the current `ptr`, back-to-back after the first. No duplicates.
- **Backpressure, stall and coalescing:**
  - Hold event_ready=0 and set keys 0 -> 8'hFF -> fifo_count reaches 8 and stays there.
  - Clear keys[0] -> no push, `ptr` stalls at 0.
  - Pulse keys[1] low for 3 clocks and back high -> nothing queued for key 1.
  - Pop one -> fifo_count becomes 8 again after the release event {0,0} is pushed. Drain all -> 9 events total, none for key 1's pulse.
- **Enable gating:** enable=0, keys 0 -> 8'h81 -> no event for 20 clocks. enable=1 -> press events for keys 0 and 7 follow.
- **Asynchronous reset mid-stream:** with fifo_count=5, assert reset between clock edges -> event_valid=0 and fifo_count=0 immediately. After release, the PRIME cycle generates no events for current keys.
